// File: rtl/mux_pkg.sv
// Shared definitions for the mux/arbiter family: mode encodings and select-width helper.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // max(1, clog2(n)) so every sibling mux sizes its select identically.
  function automatic int unsigned calc_sel_w(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_arb_nin_if.sv
// Handshake bundle for mux_arb_nin: N producer channels in, one registered consumer port out.
interface mux_arb_nin_if
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH  = 3,
  parameter int unsigned NUM_IN = 3
) ();

  localparam int unsigned SEL_W = calc_sel_w(NUM_IN);

  logic                    Mode;
  logic [SEL_W-1:0]        Sel;
  logic [NUM_IN*WIDTH-1:0] In_Data;
  logic [NUM_IN-1:0]       In_Valid;
  logic [NUM_IN-1:0]       In_Ready;
  logic [WIDTH-1:0]        Out_Data;
  logic [SEL_W-1:0]        Out_Chan;
  logic                    Out_Valid;
  logic                    Out_Ready;

  modport slave (
    input  Mode, Sel, In_Data, In_Valid, Out_Ready,
    output In_Ready, Out_Data, Out_Chan, Out_Valid
  );

  modport master (
    output Mode, Sel, In_Data, In_Valid, Out_Ready,
    input  In_Ready, Out_Data, Out_Chan, Out_Valid
  );

endinterface

// File: rtl/rr_pick_nin.sv
// Combinational round-robin picker: first valid channel strictly after i_ptr, wrapping.
module rr_pick_nin
  import mux_pkg::*;
#(
  parameter  int unsigned NUM_IN = 3,
  localparam int unsigned SEL_W  = calc_sel_w(NUM_IN)
) (
  input  logic [NUM_IN-1:0] i_valid,
  input  logic [SEL_W-1:0]  i_ptr,
  output logic [SEL_W-1:0]  o_grant,
  output logic              o_grant_any
);

  always_comb begin
    int unsigned c;
    c           = 0;
    o_grant     = '0;
    o_grant_any = 1'b0;
    for (int unsigned off = 1; off <= NUM_IN; off++) begin
      c = int'(i_ptr) + off;
      if (c >= NUM_IN) c = c - NUM_IN;
      if (!o_grant_any && i_valid[c]) begin
        o_grant     = SEL_W'(c);
        o_grant_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_arb_nin.sv
// N-input selector/arbiter with registered output stage; fixed-select or round-robin mode.
// Define MUX_ARB_SEL_ERR_EN to add the sticky out-of-range-select flag Sel_Err.
module mux_arb_nin
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = 3,
  parameter  int unsigned NUM_IN = 3,
  localparam int unsigned SEL_W  = calc_sel_w(NUM_IN)
) (
  input  logic         CLK,
  input  logic         Reset_n,
  mux_arb_nin_if.slave bus
`ifdef MUX_ARB_SEL_ERR_EN
  ,
  output logic         Sel_Err
`endif
);

  logic                 w_load;
  logic                 w_fix_any;
  logic                 w_rr_any;
  logic                 w_gnt_any;
  logic [SEL_W-1:0]     w_rr_idx;
  logic [SEL_W-1:0]     w_gnt_idx;
  logic [WIDTH-1:0]     w_gnt_data;
  logic [NUM_IN-1:0]    w_in_ready;

  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_out_data;
  logic [SEL_W-1:0]     r_out_chan;
  logic [SEL_W-1:0]     r_ptr;

  // Gated by Reset_n so no producer sees ready while the block is held in reset.
  assign w_load = Reset_n && (!r_out_valid || bus.Out_Ready);

  // An out-of-range Sel matches no channel, so it simply yields no grant.
  always_comb begin
    w_fix_any = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (bus.Sel == SEL_W'(k) && bus.In_Valid[k]) w_fix_any = 1'b1;
    end
  end

  rr_pick_nin #(
    .NUM_IN (NUM_IN)
  ) u_rr_pick (
    .i_valid     (bus.In_Valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_rr_idx),
    .o_grant_any (w_rr_any)
  );

  always_comb begin
    w_gnt_any = (bus.Mode == MODE_RR) ? w_rr_any : w_fix_any;
    w_gnt_idx = (bus.Mode == MODE_RR) ? w_rr_idx : bus.Sel;
  end

  always_comb begin
    w_gnt_data = '0;
    w_in_ready = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (w_gnt_idx == SEL_W'(k)) begin
        w_gnt_data    = bus.In_Data[k*WIDTH +: WIDTH];
        w_in_ready[k] = w_load && w_gnt_any;
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= SEL_W'(NUM_IN - 1);
    end else if (w_load) begin
      if (w_gnt_any) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_gnt_data;
        r_out_chan  <= w_gnt_idx;
        if (bus.Mode == MODE_RR) r_ptr <= w_gnt_idx;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.In_Ready  = w_in_ready;
  assign bus.Out_Valid = r_out_valid;
  assign bus.Out_Data  = r_out_data;
  assign bus.Out_Chan  = r_out_chan;

`ifdef MUX_ARB_SEL_ERR_EN
  localparam logic [SEL_W:0] NUM_IN_X = (SEL_W+1)'(NUM_IN);

  logic w_sel_oor;
  logic r_sel_err;

  assign w_sel_oor = (bus.Mode == MODE_FIXED) && ({1'b0, bus.Sel} >= NUM_IN_X);

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) r_sel_err <= 1'b0;
    else if (w_sel_oor) r_sel_err <= 1'b1;
  end

  assign Sel_Err = r_sel_err;
`endif

endmodule

// File: tb/tb_mux_arb_nin.sv
// Randomised + directed bench for mux_arb_nin against a cycle-level reference model.
module tb_mux_arb_nin;

  localparam int W  = 3;
  localparam int NI = 3;
  localparam int SW = 2;

  logic clk;
  logic rst_n;
`ifdef MUX_ARB_SEL_ERR_EN
  logic sel_err;
`endif

  mux_arb_nin_if #(.WIDTH(W), .NUM_IN(NI)) bus ();

  mux_arb_nin #(
    .WIDTH  (W),
    .NUM_IN (NI)
  ) dut (
    .CLK     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
`ifdef MUX_ARB_SEL_ERR_EN
    ,
    .Sel_Err (sel_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int           m_ptr;
  int           m_oc;
  logic         m_ov;
  logic [W-1:0] m_od;
  logic         m_err;
  logic [NI-1:0] last_rdy;

  function automatic void model_reset();
    m_ptr = NI - 1;
    m_oc  = 0;
    m_ov  = 1'b0;
    m_od  = '0;
    m_err = 1'b0;
  endfunction

  function automatic int model_grant(input logic m, input int s, input logic [NI-1:0] v);
    int c;
    if (m == 1'b0) begin
      if (s < NI) begin
        if (v[s]) return s;
      end
      return -1;
    end
    for (int off = 1; off <= NI; off++) begin
      c = (m_ptr + off) % NI;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic cycle(input logic m, input logic [SW-1:0] s, input logic [NI-1:0] v,
                       input logic [NI*W-1:0] d, input logic ordy);
    int            g;
    logic          ld;
    logic [NI-1:0] er;
    bus.Mode      = m;
    bus.Sel       = s;
    bus.In_Valid  = v;
    bus.In_Data   = d;
    bus.Out_Ready = ordy;
    #2;
    g  = model_grant(m, int'(s), v);
    ld = !m_ov || ordy;
    er = '0;
    if (ld && g >= 0) er[g] = 1'b1;
    last_rdy = bus.In_Ready;
    check_eq("in_ready", 32'(last_rdy), 32'(er));
    @(posedge clk);
    #1;
    if (m == 1'b0 && int'(s) >= NI) m_err = 1'b1;
    if (ld) begin
      if (g >= 0) begin
        m_od = d[g*W +: W];
        m_oc = g;
        m_ov = 1'b1;
        if (m) m_ptr = g;
      end else begin
        m_ov = 1'b0;
      end
    end
    check_eq("out_valid", 32'(bus.Out_Valid), 32'(m_ov));
    check_eq("out_data",  32'(bus.Out_Data),  32'(m_od));
    check_eq("out_chan",  32'(bus.Out_Chan),  m_oc);
`ifdef MUX_ARB_SEL_ERR_EN
    check_eq("sel_err",   32'(sel_err),       32'(m_err));
`endif
  endtask

  // Asynchronous reset pulse entirely between clock edges.
  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check_eq("areset_valid", 32'(bus.Out_Valid), 0);
    check_eq("areset_data",  32'(bus.Out_Data),  0);
    check_eq("areset_ready", 32'(bus.In_Ready),  0);
`ifdef MUX_ARB_SEL_ERR_EN
    check_eq("areset_err",   32'(sel_err),       0);
`endif
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  localparam logic [NI*W-1:0] DIR_DATA = {3'd5, 3'd2, 3'd7};

  initial begin
    logic [31:0] rnd;
    int          exp_seq [10];

    rst_n         = 1'b0;
    bus.Mode      = 1'b1;
    bus.Sel       = '0;
    bus.In_Valid  = '1;
    bus.In_Data   = DIR_DATA;
    bus.Out_Ready = 1'b1;
    model_reset();
    #12;
    check_eq("rst_valid", 32'(bus.Out_Valid), 0);
    check_eq("rst_data",  32'(bus.Out_Data),  0);
    check_eq("rst_ready", 32'(bus.In_Ready),  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cycle(1'b1, 2'd0, 3'b111, DIR_DATA, 1'b1);
    check_eq("first_rr_chan", 32'(bus.Out_Chan), 0);

    // Fixed select of channel 2
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'd2, 3'b111, DIR_DATA, 1'b1);
      check_eq("fix_ready", 32'(last_rdy),      32'b100);
      check_eq("fix_data",  32'(bus.Out_Data),  5);
      check_eq("fix_chan",  32'(bus.Out_Chan),  2);
    end

    // Out-of-range select
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 2'd3, 3'b111, DIR_DATA, 1'b1);
      check_eq("oor_ready", 32'(last_rdy),     0);
      check_eq("oor_valid", 32'(bus.Out_Valid), 0);
      check_eq("oor_data",  32'(bus.Out_Data),  5);
`ifdef MUX_ARB_SEL_ERR_EN
      check_eq("oor_err",   32'(sel_err),       1);
`endif
    end
    cycle(1'b0, 2'd0, 3'b111, DIR_DATA, 1'b1);
`ifdef MUX_ARB_SEL_ERR_EN
    check_eq("err_sticky", 32'(sel_err), 1);
`endif

    // Round-robin fairness from a fresh pointer
    pulse_reset();
    exp_seq = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 2'd0, (i < 6) ? 3'b111 : 3'b101, DIR_DATA, 1'b1);
      check_eq("rr_chan",  32'(bus.Out_Chan),  exp_seq[i]);
      check_eq("rr_valid", 32'(bus.Out_Valid), 1);
    end

    // Back-pressure: output holds, no readies, pointer frozen
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 2'd0, 3'b111, DIR_DATA, 1'b0);
      check_eq("bp_ready", 32'(last_rdy),      0);
      check_eq("bp_chan",  32'(bus.Out_Chan),  2);
      check_eq("bp_data",  32'(bus.Out_Data),  5);
    end
    cycle(1'b1, 2'd0, 3'b111, DIR_DATA, 1'b1);
    check_eq("bp_drain_chan", 32'(bus.Out_Chan), 0);
    check_eq("bp_drain_data", 32'(bus.Out_Data), 7);

    // Async reset mid-stream, then restart at channel 0
    cycle(1'b1, 2'd0, 3'b111, DIR_DATA, 1'b0);
    check_eq("pre_areset_valid", 32'(bus.Out_Valid), 1);
    pulse_reset();
    cycle(1'b1, 2'd0, 3'b111, DIR_DATA, 1'b1);
    check_eq("post_areset_chan", 32'(bus.Out_Chan), 0);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom;
      cycle(rnd[31], rnd[SW-1:0], rnd[NI+7:8], rnd[NI*W+15:16],
            ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
